refill_return_buffer: RTL and testbench
=======================================

REFILL_RETURN_BUFFER -- requirements
Module: refill_return_buffer

Interface
REQ-001 Parameter WORDS, default 4, words per cache line; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32, AXI read-data width in bits.
REQ-003 Derived localparam OFF_W = log2(WORDS), word-offset width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  refill AR accepted this cycle; starts a fill.
REQ-007 req_offset  input  OFF_W  word offset the pipeline is waiting on.
REQ-008 rvalid  input  1  AXI R beat valid.
REQ-009 rready  output  1  AXI R ready.
REQ-010 rdata  input  DATA_W  AXI R data.
REQ-011 rresp  input  2  AXI R response; nonzero = error.
REQ-012 rlast  input  1  AXI R last beat.
REQ-013 line_data  output  WORDS*DATA_W  assembled line; word i at bits [i*DATA_W +: DATA_W].
REQ-014 line_valid  output  1  line complete, held until acknowledged.
REQ-015 line_err  output  1  sticky error for the current line; valid while line_valid=1.
REQ-016 line_ack  input  1  consumer has written the line into cache RAM.
REQ-017 crit_valid  output  1  one-cycle pulse: requested word available.
REQ-018 crit_data  output  DATA_W  requested word; valid when crit_valid=1.
REQ-019 busy  output  1  high in any state other than IDLE.

Function
REQ-020 The block SHALL implement three states: IDLE, FILL, FULL.
REQ-021 IDLE: rready=0, line_valid=0; req_valid=1 -> FILL next cycle, beat counter cnt:=0, offset register:=req_offset, line_err:=0.
REQ-022 FILL: rready=1; a beat is accepted only when rvalid=1 and rready=1.
REQ-023 An accepted beat SHALL write rdata into word cnt of line_data and increment cnt (OFF_W bits, wraps).
REQ-024 Words not yet written in the current fill SHALL retain their previous contents.
REQ-025 An accepted beat with cnt == captured offset SHALL give crit_valid=1 and crit_data=rdata in the next cycle only (latency 1).
REQ-026 An accepted beat with rresp != 0 SHALL set line_err; line_err stays set until the next fill starts.
REQ-027 An accepted beat with rlast=1 SHALL move FILL -> FULL; line_valid=1 from the next cycle.
REQ-028 Early rlast (cnt < WORDS-1) SHALL also move to FULL and set line_err.
REQ-029 An accepted beat with cnt == WORDS-1 and rlast=0 SHALL move to FULL and set line_err; later beats are not accepted (rready=0).
REQ-030 FULL: rready=0, line_valid=1, line_data stable; line_ack=1 -> IDLE next cycle.
REQ-031 FULL with line_ack=1 and req_valid=1 in the same cycle SHALL go directly to FILL with IDLE-entry initialisation (back-to-back refill).
REQ-032 req_valid in FILL, or in FULL without line_ack, SHALL be ignored.
REQ-033 line_ack outside FULL SHALL be ignored.
REQ-034 rready, line_valid, and busy SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-035 rstn=0 SHALL immediately force: state IDLE, cnt=0, offset=0, line_data=0, line_err=0, crit_valid=0, crit_data=0, rready=0, line_valid=0, busy=0.
REQ-036 Reset during FILL or FULL SHALL abandon the line; after release no crit_valid or line_valid is produced until a new req_valid.

Verification
REQ-037 WORDS=4, DATA_W=32, req_offset=2; beats 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, rlast on the 4th -> crit_valid one cycle after beat 3 with crit_data=0xA2; line_valid from cycle after beat 4; line_data=0xA3A2A1A0 word order; line_err=0.
REQ-038 Same stimulus with rvalid gaps of 2 cycles between beats -> identical line_data; crit_valid pulse is exactly 1 cycle wide.
REQ-039 Beat 1 with rresp=2'b10 -> line_err=1 in FULL; next fill with clean beats -> line_err=0.
REQ-040 rlast on beat 2 of 4 -> FULL, line_err=1, words 2-3 hold the previous line's values.
REQ-041 In FULL, assert line_ack and req_valid together -> next cycle state FILL, rready=1, line_valid=0; new line assembles correctly.
REQ-042 Assert rstn=0 mid-FILL after 2 beats -> all outputs 0 immediately; after release, rvalid beats with rready=0 produce no crit_valid or line_valid.

Source files
------------

// File: rtl/refill_return_buffer.sv
// Cache refill return buffer: assembles AXI R beats into a line, forwards the
// requested (critical) word one cycle after it arrives, and holds the line until acked.
module refill_return_buffer #(
  parameter int unsigned WORDS  = 4,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned OFF_W = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req_valid,
  input  logic [OFF_W-1:0]        req_offset,
  input  logic                    rvalid,
  output logic                    rready,
  input  logic [DATA_W-1:0]       rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  output logic [WORDS*DATA_W-1:0] line_data,
  output logic                    line_valid,
  output logic                    line_err,
  input  logic                    line_ack,
  output logic                    crit_valid,
  output logic [DATA_W-1:0]       crit_data,
  output logic                    busy
);

  localparam logic [OFF_W-1:0] LastIdx = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StFill, StFull} state_e;

  state_e              state_q;
  logic [OFF_W-1:0]    cnt_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_W-1:0]   words_q [WORDS];
  logic                err_q;
  logic                crit_valid_q;
  logic [DATA_W-1:0]   crit_data_q;

  logic beat;
  logic last_idx;
  logic start;

  assign beat     = (state_q == StFill) && rvalid;
  assign last_idx = (cnt_q == LastIdx);
  // A new fill may start from IDLE, or straight out of FULL when the line is acked.
  assign start    = req_valid && ((state_q == StIdle) || ((state_q == StFull) && line_ack));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      off_q        <= '0;
      err_q        <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      for (int i = 0; i < WORDS; i++) words_q[i] <= '0;
    end else begin
      crit_valid_q <= 1'b0;
      if (start) begin
        state_q <= StFill;
        cnt_q   <= '0;
        off_q   <= req_offset;
        err_q   <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: ;
          StFill: begin
            if (beat) begin
              words_q[cnt_q] <= rdata;
              cnt_q          <= cnt_q + OFF_W'(1);
              if (cnt_q == off_q) begin
                crit_valid_q <= 1'b1;
                crit_data_q  <= rdata;
              end
              // Error on bad response, early rlast, or a missing rlast on the final word.
              if ((rresp != 2'b00) || (rlast != last_idx)) err_q <= 1'b1;
              if (rlast || last_idx) state_q <= StFull;
            end
          end
          StFull: if (line_ack) state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  for (genvar i = 0; i < WORDS; i++) begin : g_line
    assign line_data[i*DATA_W +: DATA_W] = words_q[i];
  end

  assign rready     = (state_q == StFill);
  assign line_valid = (state_q == StFull);
  assign busy       = (state_q != StIdle);
  assign line_err   = err_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;

endmodule

// File: tb/tb_refill_return_buffer.sv
// Directed bench for refill_return_buffer (WORDS=4, DATA_W=32).
module tb_refill_return_buffer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid;
  logic [1:0]   req_offset;
  logic         rvalid;
  logic         rready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic [127:0] line_data;
  logic         line_valid;
  logic         line_err;
  logic         line_ack;
  logic         crit_valid;
  logic [31:0]  crit_data;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  refill_return_buffer #(.WORDS(4), .DATA_W(32)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_offset (req_offset),
    .rvalid     (rvalid),
    .rready     (rready),
    .rdata      (rdata),
    .rresp      (rresp),
    .rlast      (rlast),
    .line_data  (line_data),
    .line_valid (line_valid),
    .line_err   (line_err),
    .line_ack   (line_ack),
    .crit_valid (crit_valid),
    .crit_data  (crit_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fill(input logic [1:0] off);
    req_valid = 1'b1; req_offset = off;
    cyc();
    req_valid = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last);
    rvalid = 1'b1; rdata = d; rresp = resp; rlast = last;
    cyc();
    rvalid = 1'b0; rresp = 2'b00; rlast = 1'b0;
  endtask

  task automatic ack();
    line_ack = 1'b1;
    cyc();
    line_ack = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; req_valid = 0; req_offset = 0; rvalid = 0; rdata = 0;
    rresp = 0; rlast = 0; line_ack = 0;
    #2;
    n_checks++;
    if ({rready, line_valid, line_err, crit_valid, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {rready, line_valid, line_err, crit_valid, busy});
    end
    n_checks++;
    if ({line_data, crit_data} !== 160'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h expected 0", line_data, crit_data);
    end
    cyc();
    rstn = 1'b1;
    cyc();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    start_fill(2'd2);
    n_checks++;
    if ({busy, rready, line_valid} !== 3'b110) begin
      n_fail++; $display("FAIL fill_entry: got %b expected 110", {busy, rready, line_valid});
    end
    beat(32'hA0, 2'b00, 1'b0);
    beat(32'hA1, 2'b00, 1'b0);
    n_checks++;
    if (crit_valid !== 1'b0) begin
      n_fail++; $display("FAIL crit_early: got %b expected 0", crit_valid);
    end
    beat(32'hA2, 2'b00, 1'b0);
    n_checks++;
    if ({crit_valid, crit_data} !== {1'b1, 32'hA2}) begin
      n_fail++; $display("FAIL crit_word: got %b %h expected 1 000000a2", crit_valid, crit_data);
    end
    beat(32'hA3, 2'b00, 1'b1);
    n_checks++;
    if ({crit_valid, line_valid, line_err, rready} !== 4'b0100) begin
      n_fail++; $display("FAIL full_ctrl: got %b expected 0100",
                         {crit_valid, line_valid, line_err, rready});
    end
    n_checks++;
    if (line_data !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_fail++; $display("FAIL basic_line: got %h expected a3a2a1a0 words", line_data);
    end
    // line_ack outside FULL must not matter; inside FULL it returns to IDLE.
    ack();
    n_checks++;
    if ({busy, line_valid} !== 2'b00) begin
      n_fail++; $display("FAIL ack_idle: got %b expected 00", {busy, line_valid});
    end
    ack();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stray_ack: got %b expected 0", busy); end
  endtask

  task automatic test_gaps();
    logic [31:0] d;
    int pulses;
    pulses = 0;
    start_fill(2'd2);
    for (int i = 0; i < 4; i++) begin
      d = 32'hA0 + 32'(i);
      beat(d, 2'b00, i == 3);
      if (crit_valid) pulses++;
      if (i == 2) begin
        n_checks++;
        if ({crit_valid, crit_data} !== {1'b1, 32'hA2}) begin
          n_fail++; $display("FAIL gap_crit: got %b %h expected 1 000000a2", crit_valid, crit_data);
        end
      end
      for (int g = 0; g < 2; g++) begin
        cyc();
        if (crit_valid) pulses++;
      end
    end
    n_checks++;
    if (pulses !== 1) begin n_fail++; $display("FAIL gap_pulse: got %0d expected 1", pulses); end
    n_checks++;
    if ({line_valid, line_err, line_data} !== {2'b10, 128'h000000A3_000000A2_000000A1_000000A0})
    begin
      n_fail++; $display("FAIL gap_line: got %b %b %h", line_valid, line_err, line_data);
    end
    ack();
  endtask

  task automatic test_error();
    start_fill(2'd0);
    beat(32'hB0, 2'b00, 1'b0);
    beat(32'hB1, 2'b10, 1'b0);
    beat(32'hB2, 2'b00, 1'b0);
    beat(32'hB3, 2'b00, 1'b1);
    n_checks++;
    if ({line_valid, line_err} !== 2'b11) begin
      n_fail++; $display("FAIL resp_err: got %b expected 11", {line_valid, line_err});
    end
    ack();
    start_fill(2'd0);
    n_checks++;
    if (line_err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", line_err); end
    beat(32'hC0, 2'b00, 1'b0);
    n_checks++;
    if ({crit_valid, crit_data} !== {1'b1, 32'hC0}) begin
      n_fail++; $display("FAIL crit_off0: got %b %h expected 1 000000c0", crit_valid, crit_data);
    end
    beat(32'hC1, 2'b00, 1'b0);
    beat(32'hC2, 2'b00, 1'b0);
    beat(32'hC3, 2'b00, 1'b1);
    n_checks++;
    if ({line_valid, line_err} !== 2'b10) begin
      n_fail++; $display("FAIL clean_line: got %b expected 10", {line_valid, line_err});
    end
    ack();
  endtask

  task automatic test_early_last();
    start_fill(2'd3);
    beat(32'hD0, 2'b00, 1'b0);
    beat(32'hD1, 2'b00, 1'b1);
    n_checks++;
    if ({line_valid, line_err, rready} !== 3'b110) begin
      n_fail++; $display("FAIL early_ctrl: got %b expected 110", {line_valid, line_err, rready});
    end
    n_checks++;
    if (line_data !== 128'h000000C3_000000C2_000000D1_000000D0) begin
      n_fail++; $display("FAIL early_line: got %h expected c3c2d1d0 words", line_data);
    end
    ack();
  endtask

  task automatic test_overrun();
    start_fill(2'd1);
    for (int i = 0; i < 4; i++) beat(32'hE0 + 32'(i), 2'b00, 1'b0);
    n_checks++;
    if ({line_valid, line_err, rready} !== 3'b110) begin
      n_fail++; $display("FAIL overrun_ctrl: got %b expected 110", {line_valid, line_err, rready});
    end
    beat(32'hEE, 2'b00, 1'b1);
    n_checks++;
    if (line_data !== 128'h000000E3_000000E2_000000E1_000000E0) begin
      n_fail++; $display("FAIL overrun_line: got %h expected e3e2e1e0 words", line_data);
    end
  endtask

  task automatic test_back_to_back();
    // Still FULL from the overrun; a lone req_valid is ignored.
    start_fill(2'd0);
    n_checks++;
    if ({line_valid, rready} !== 2'b10) begin
      n_fail++; $display("FAIL req_in_full: got %b expected 10", {line_valid, rready});
    end
    req_valid = 1'b1; req_offset = 2'd1; line_ack = 1'b1;
    cyc();
    req_valid = 1'b0; line_ack = 1'b0;
    n_checks++;
    if ({busy, rready, line_valid, line_err} !== 4'b1100) begin
      n_fail++; $display("FAIL b2b_entry: got %b expected 1100", {busy, rready, line_valid, line_err});
    end
    beat(32'hF0, 2'b00, 1'b0);
    beat(32'hF1, 2'b00, 1'b0);
    n_checks++;
    if ({crit_valid, crit_data} !== {1'b1, 32'hF1}) begin
      n_fail++; $display("FAIL b2b_crit: got %b %h expected 1 000000f1", crit_valid, crit_data);
    end
    beat(32'hF2, 2'b00, 1'b0);
    beat(32'hF3, 2'b00, 1'b1);
    n_checks++;
    if ({line_valid, line_err, line_data} !== {2'b10, 128'h000000F3_000000F2_000000F1_000000F0})
    begin
      n_fail++; $display("FAIL b2b_line: got %b %b %h", line_valid, line_err, line_data);
    end
    ack();
  endtask

  task automatic test_reset_mid_fill();
    int bad;
    bad = 0;
    start_fill(2'd2);
    beat(32'h10, 2'b00, 1'b0);
    beat(32'h11, 2'b00, 1'b0);
    #2 rstn = 1'b0;
    #1;
    n_checks++;
    if ({rready, line_valid, line_err, crit_valid, busy, line_data, crit_data} !== 165'h0) begin
      n_fail++; $display("FAIL async_reset: got %b %h %h",
                         {rready, line_valid, line_err, crit_valid, busy}, line_data, crit_data);
    end
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rvalid = 1'b1; rdata = 32'h20 + 32'(i); rlast = (i == 3);
      cyc();
      if (rready || crit_valid || line_valid || busy) bad++;
    end
    rvalid = 1'b0; rlast = 1'b0;
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL post_reset: got %0d active cycles expected 0", bad); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_error();
    test_early_last();
    test_overrun();
    test_back_to_back();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
